// File: rtl/fifo_pkg.sv
// fifo_pkg: default sizing constants shared by the FIFO top and its controller
package fifo_pkg;
    localparam int DefaultAddrBits   = 3;
    localparam int DefaultWordLength = 8;
endpackage

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: FIFO pointer/flag controller driving register-file enables and addresses.
// Flags decode only from registered pointers; enables are the sole input-to-output paths.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int AddrBits          = DefaultAddrBits,
    parameter int AlmostFullThresh  = 6,
    parameter int AlmostEmptyThresh = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wr_i,
    input  logic                rd_i,
    output logic                wr_en_o,
    output logic                rd_en_o,
    output logic [AddrBits-1:0] w_addr_o,
    output logic [AddrBits-1:0] r_addr_o,
    output logic                full_o,
    output logic                empty_o,
    output logic                almost_full_o,
    output logic                almost_empty_o,
    output logic [AddrBits:0]   count_o,
    output logic                rd_valid_o,
    output logic                overflow_o,
    output logic                underflow_o
);
    localparam logic [AddrBits:0] AfThresh = (AddrBits+1)'(AlmostFullThresh);
    localparam logic [AddrBits:0] AeThresh = (AddrBits+1)'(AlmostEmptyThresh);
    logic [AddrBits:0] wptr, rptr;
    assign w_addr_o       = wptr[AddrBits-1:0];
    assign r_addr_o       = rptr[AddrBits-1:0];
    assign count_o        = wptr - rptr;
    assign empty_o        = wptr == rptr;
    assign full_o         = (w_addr_o == r_addr_o) && (wptr[AddrBits] != rptr[AddrBits]);
    assign almost_full_o  = count_o >= AfThresh;
    assign almost_empty_o = count_o <= AeThresh;
    // a write while full is allowed only when a read frees the slot at the same edge
    assign rd_en_o        = rd_i & ~empty_o;
    assign wr_en_o        = wr_i & (~full_o | rd_i);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr        <= '0;
            rptr        <= '0;
            rd_valid_o  <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            wptr        <= wptr + (AddrBits+1)'(wr_en_o);
            rptr        <= rptr + (AddrBits+1)'(rd_en_o);
            rd_valid_o  <= rd_en_o;
            overflow_o  <= wr_i & ~wr_en_o;
            underflow_o <= rd_i & ~rd_en_o;
        end
    end
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: scoreboard bench; an occupancy/transfer-count model predicts every cycle's outputs.
module tb_fifo_ctrl;
    localparam int AW = 3, DEPTH = 8, AF = 6, AE = 2;

    logic clk = 1'b0, rst_i = 1'b1, wr_i = 1'b0, rd_i = 1'b0;
    logic wr_en_o, rd_en_o, full_o, empty_o, almost_full_o, almost_empty_o;
    logic rd_valid_o, overflow_o, underflow_o;
    logic [AW-1:0] w_addr_o, r_addr_o;
    logic [AW:0]   count_o;

    fifo_ctrl #(.AddrBits(AW), .AlmostFullThresh(AF), .AlmostEmptyThresh(AE)) dut (
        .clk_i(clk), .rst_i(rst_i), .wr_i(wr_i), .rd_i(rd_i),
        .wr_en_o(wr_en_o), .rd_en_o(rd_en_o), .w_addr_o(w_addr_o), .r_addr_o(r_addr_o),
        .full_o(full_o), .empty_o(empty_o), .almost_full_o(almost_full_o),
        .almost_empty_o(almost_empty_o), .count_o(count_o), .rd_valid_o(rd_valid_o),
        .overflow_o(overflow_o), .underflow_o(underflow_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic wr_en, rd_en;
        logic [AW-1:0] wa, ra;
        logic [AW:0] cnt;
        logic full, empty, af, ae, rv, ov, un;
    } exp_t;

    exp_t sbq[$];
    int compared = 0, mismatched = 0;
    int m_cnt = 0, m_wtot = 0, m_rtot = 0;
    bit m_rv = 0, m_ov = 0, m_un = 0;

    task automatic cmp(input string name, input logic [8:0] act, input logic [8:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_wtot = 0; m_rtot = 0; m_rv = 0; m_ov = 0; m_un = 0;
    endtask

    // one cycle: drive inputs, push the outputs expected until the next edge, advance the model
    task automatic step(input bit w, input bit r);
        exp_t e;
        bit we, re;
        @(posedge clk);
        #2;
        wr_i = w;
        rd_i = r;
        re = r && m_cnt > 0;
        we = w && (m_cnt < DEPTH || r);
        e.wr_en = we;
        e.rd_en = re;
        e.wa    = AW'(m_wtot % DEPTH);
        e.ra    = AW'(m_rtot % DEPTH);
        e.cnt   = (AW+1)'(m_cnt);
        e.full  = m_cnt == DEPTH;
        e.empty = m_cnt == 0;
        e.af    = m_cnt >= AF;
        e.ae    = m_cnt <= AE;
        e.rv    = m_rv;
        e.ov    = m_ov;
        e.un    = m_un;
        sbq.push_back(e);
        m_cnt  = m_cnt + int'(we) - int'(re);
        m_wtot = m_wtot + int'(we);
        m_rtot = m_rtot + int'(re);
        m_rv   = re;
        m_ov   = w && !we;
        m_un   = r && !re;
    endtask

    task automatic check_reset_outputs(input string tag);
        cmp({tag, "_count"}, 9'(count_o), 9'd0);
        cmp({tag, "_empty"}, 9'(empty_o), 9'd1);
        cmp({tag, "_aempty"}, 9'(almost_empty_o), 9'd1);
        cmp({tag, "_full"}, 9'(full_o), 9'd0);
        cmp({tag, "_afull"}, 9'(almost_full_o), 9'd0);
        cmp({tag, "_waddr"}, 9'(w_addr_o), 9'd0);
        cmp({tag, "_raddr"}, 9'(r_addr_o), 9'd0);
        cmp({tag, "_pulses"}, 9'({rd_valid_o, overflow_o, underflow_o}), 9'd0);
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            cmp("wr_en", 9'(wr_en_o), 9'(e.wr_en));
            cmp("rd_en", 9'(rd_en_o), 9'(e.rd_en));
            cmp("w_addr", 9'(w_addr_o), 9'(e.wa));
            cmp("r_addr", 9'(r_addr_o), 9'(e.ra));
            cmp("count", 9'(count_o), 9'(e.cnt));
            cmp("full", 9'(full_o), 9'(e.full));
            cmp("empty", 9'(empty_o), 9'(e.empty));
            cmp("almost_full", 9'(almost_full_o), 9'(e.af));
            cmp("almost_empty", 9'(almost_empty_o), 9'(e.ae));
            cmp("rd_valid", 9'(rd_valid_o), 9'(e.rv));
            cmp("overflow", 9'(overflow_o), 9'(e.ov));
            cmp("underflow", 9'(underflow_o), 9'(e.un));
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("por");
        rst_i = 1'b0;
        repeat (3) step(0, 0);
        repeat (9) step(1, 0);
        repeat (3) step(1, 1);
        repeat (8) step(0, 1);
        step(0, 1);
        step(1, 1);
        step(0, 1);
        for (int i = 0; i < 20; i++) begin
            step(1, 0);
            step(0, 1);
        end
        step(0, 0);
        repeat (5) step(1, 0);
        @(posedge clk);
        #2;
        wr_i = 1'b0;
        rd_i = 1'b0;
        rst_i = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(posedge clk);
        #2;
        rst_i = 1'b0;
        for (int i = 0; i < 400; i++) begin
            int bias;
            bias = (i / 50) % 2 ? 3 : 1;
            step(($urandom % 4) < bias ? 1'b1 : 1'b0, ($urandom % 4) < 4 - bias ? 1'b1 : 1'b0);
        end
        repeat (DEPTH + 1) step(0, 1);
        step(0, 0);
        repeat (3) @(negedge clk);
        cmp("sb_drained", 9'(sbq.size()), 9'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
